// File: rtl/seq_monitor_pkg.sv
// Shared definitions for the JK sequence-generator monitor: FSM states,
// cycle heads and the successor/membership rules for both sequences.
package seq_monitor_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_e;

  localparam logic [2:0] SEQ0_HEAD = 3'd0;
  localparam logic [2:0] SEQ1_HEAD = 3'd1;

  // Mode 0 skips codes 1, 5 and 6; mode 1 only skips code 0.
  function automatic logic is_member(input logic mode, input logic [2:0] q);
    logic m;
    m = 1'b0;
    if (mode) begin
      m = (q != 3'd0);
    end else begin
      case (q)
        3'd0, 3'd2, 3'd3, 3'd4, 3'd7: m = 1'b1;
        default:                      m = 1'b0;
      endcase
    end
    return m;
  endfunction

  // Non-members return 0; callers must qualify the result with is_member.
  function automatic logic [2:0] succ(input logic mode, input logic [2:0] q);
    logic [2:0] s;
    s = 3'd0;
    if (mode) begin
      case (q)
        3'd1:    s = 3'd4;
        3'd4:    s = 3'd3;
        3'd3:    s = 3'd5;
        3'd5:    s = 3'd7;
        3'd7:    s = 3'd6;
        3'd6:    s = 3'd2;
        3'd2:    s = 3'd1;
        default: s = 3'd0;
      endcase
    end else begin
      case (q)
        3'd0:    s = 3'd4;
        3'd4:    s = 3'd7;
        3'd7:    s = 3'd2;
        3'd2:    s = 3'd3;
        3'd3:    s = 3'd0;
        default: s = 3'd0;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/seq_succ_lut.sv
// Combinational {mode,q} -> {member,succ} lookup, shared with the
// generators' own self-check bench.
module seq_succ_lut
  import seq_monitor_pkg::*;
(
  input  logic       mode_i,
  input  logic [2:0] q_i,
  output logic       member_o,
  output logic [2:0] succ_o
);

  assign member_o = is_member(mode_i, q_i);
  assign succ_o   = succ(mode_i, q_i);

endmodule

// File: rtl/seq_monitor.sv
// Sequence checker for the 3-bit JK generators: hunts for a member code,
// acquires LOCK_N correct steps, then flags mismatches and counts laps.
module seq_monitor
  import seq_monitor_pkg::*;
#(
  parameter int LOCK_N = 3,
  parameter int ERR_W  = 8,
  parameter int LAP_W  = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       q,
  input  logic             mode,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_cnt,
  output logic [LAP_W-1:0] lap_cnt
);

  localparam int RUN_W = 4;
  localparam logic [RUN_W-1:0] LOCK_TGT = RUN_W'(LOCK_N);

  state_e           state_q, state_d;
  logic [2:0]       exp_q, exp_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             mode_q;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [LAP_W-1:0] lap_cnt_q, lap_cnt_d;

  logic             member;
  logic [2:0]       nxt;
  logic [2:0]       head;
  logic [RUN_W-1:0] run_inc;
  logic [ERR_W-1:0] err_base;
  logic [LAP_W-1:0] lap_base;

  // mode_q equals mode whenever a sample is actually evaluated.
  seq_succ_lut u_lut (
    .mode_i   (mode_q),
    .q_i      (q),
    .member_o (member),
    .succ_o   (nxt)
  );

  assign head    = mode_q ? SEQ1_HEAD : SEQ0_HEAD;
  assign run_inc = run_q + 1'b1;

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    run_d   = run_q;
    err_d   = 1'b0;
    wrap_d  = 1'b0;

    if (mode != mode_q) begin
      state_d = HUNT;
      run_d   = '0;
    end else if (en) begin
      unique case (state_q)
        HUNT: begin
          if (member) begin
            state_d = ACQ;
            exp_d   = nxt;
            run_d   = '0;
          end
        end
        ACQ: begin
          if (q == exp_q) begin
            exp_d = nxt;
            run_d = run_inc;
            if (run_inc == LOCK_TGT) state_d = LOCK;
          end else if (member) begin
            exp_d = nxt;
            run_d = '0;
          end else begin
            state_d = HUNT;
          end
        end
        LOCK: begin
          if (q == exp_q) begin
            exp_d  = nxt;
            wrap_d = (q == head);
          end else begin
            err_d = 1'b1;
            if (member) begin
              state_d = ACQ;
              exp_d   = nxt;
              run_d   = '0;
            end else begin
              state_d = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Clear is applied before the increment so a coincident pulse counts as 1.
  always_comb begin
    err_base  = clr_cnt ? '0 : err_cnt_q;
    lap_base  = clr_cnt ? '0 : lap_cnt_q;
    err_cnt_d = (err_d && (err_base != '1)) ? err_base + 1'b1 : err_base;
    lap_cnt_d = wrap_d ? lap_base + 1'b1 : lap_base;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= HUNT;
      exp_q     <= '0;
      run_q     <= '0;
      mode_q    <= 1'b0;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
      err_cnt_q <= '0;
      lap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      run_q     <= run_d;
      mode_q    <= mode;
      err_q     <= err_d;
      wrap_q    <= wrap_d;
      err_cnt_q <= err_cnt_d;
      lap_cnt_q <= lap_cnt_d;
    end
  end

  assign locked  = (state_q == LOCK);
  assign err     = err_q;
  assign wrap    = wrap_q;
  assign err_cnt = err_cnt_q;
  assign lap_cnt = lap_cnt_q;

endmodule

// File: tb/tb_seq_monitor.sv
// Self-checking bench for seq_monitor: directed scenarios plus random
// stimulus, checked every cycle against a sequence-list reference model.
module tb_seq_monitor;

  localparam int LOCK_N = 3;
  localparam int ERR_W  = 8;
  localparam int LAP_W  = 8;
  localparam int ST_H = 0, ST_A = 1, ST_L = 2;

  logic             clk = 1'b0;
  logic             clr, en, mode, clr_cnt;
  logic [2:0]       q;
  logic             locked, err, wrap;
  logic [ERR_W-1:0] err_cnt;
  logic [LAP_W-1:0] lap_cnt;

  seq_monitor #(.LOCK_N(LOCK_N), .ERR_W(ERR_W), .LAP_W(LAP_W)) dut (
    .clk(clk), .clr(clr), .en(en), .q(q), .mode(mode), .clr_cnt(clr_cnt),
    .locked(locked), .err(err), .wrap(wrap), .err_cnt(err_cnt), .lap_cnt(lap_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_on = 0;

  // Reference model: cycles as ordered lists, head at position 0.
  int seq0[5] = '{0, 4, 7, 2, 3};
  int seq1[7] = '{1, 4, 3, 5, 7, 6, 2};
  int m_st, m_exp, m_run, m_ec, m_lc;
  bit m_mode, m_err, m_wrap;

  function automatic int pos(bit md, int v);
    if (md) begin
      for (int i = 0; i < 7; i++) if (seq1[i] == v) return i;
    end else begin
      for (int i = 0; i < 5; i++) if (seq0[i] == v) return i;
    end
    return -1;
  endfunction

  function automatic int nxt(bit md, int v);
    int p;
    p = pos(md, v);
    if (md) return seq1[(p + 1) % 7];
    return seq0[(p + 1) % 5];
  endfunction

  task automatic model_reset();
    m_st = ST_H; m_exp = 0; m_run = 0; m_ec = 0; m_lc = 0;
    m_mode = 0; m_err = 0; m_wrap = 0;
  endtask

  task automatic model_tick(bit e, int qq, bit md, bit cc);
    int p;
    if (clr) begin
      model_reset();
      return;
    end
    m_err = 0; m_wrap = 0;
    if (md != m_mode) begin
      m_st = ST_H; m_run = 0;
    end else if (e) begin
      p = pos(m_mode, qq);
      if (m_st == ST_H) begin
        if (p >= 0) begin m_st = ST_A; m_exp = nxt(m_mode, qq); m_run = 0; end
      end else if (m_st == ST_A) begin
        if (qq == m_exp) begin
          m_run++; m_exp = nxt(m_mode, qq);
          if (m_run == LOCK_N) m_st = ST_L;
        end else if (p >= 0) begin
          m_exp = nxt(m_mode, qq); m_run = 0;
        end else m_st = ST_H;
      end else begin
        if (qq == m_exp) begin
          m_exp = nxt(m_mode, qq); m_wrap = (p == 0);
        end else begin
          m_err = 1;
          if (p >= 0) begin m_st = ST_A; m_run = 0; m_exp = nxt(m_mode, qq); end
          else m_st = ST_H;
        end
      end
    end
    if (cc) begin m_ec = 0; m_lc = 0; end
    if (m_err && m_ec < (1 << ERR_W) - 1) m_ec++;
    if (m_wrap) m_lc = (m_lc + 1) % (1 << LAP_W);
    m_mode = md;
  endtask

  task automatic chk(string nm, int act, int want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("locked", int'(locked), int'(m_st == ST_L));
      chk("err", int'(err), int'(m_err));
      chk("wrap", int'(wrap), int'(m_wrap));
      chk("err_cnt", int'(err_cnt), m_ec);
      chk("lap_cnt", int'(lap_cnt), m_lc);
    end
  end

  task automatic step(bit e, int qq, bit md, bit cc);
    en = e; q = 3'(qq); mode = md; clr_cnt = cc;
    @(posedge clk);
    model_tick(e, qq, md, cc);
    @(negedge clk);
  endtask

  task automatic feed(bit md, int n, int vals[15]);
    for (int i = 0; i < n; i++) step(1, vals[i], md, 0);
  endtask

  initial begin
    bit cm;
    int qq;
    int s1[15];
    clr = 1; en = 0; q = 0; mode = 0; clr_cnt = 0;
    model_reset();
    chk_on = 1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    clr = 0;

    // Mode 0 acquire and lock.
    step(1, 0, 0, 0); step(1, 4, 0, 0); step(1, 7, 0, 0); step(1, 2, 0, 0);
    chk("t1_locked", int'(locked), 1);
    step(1, 3, 0, 0); step(1, 0, 0, 0);
    chk("t1_wrap", int'(wrap), 1);
    chk("t1_lap", int'(lap_cnt), 1);
    step(1, 4, 0, 0);

    // Mismatch while locked, then relock.
    step(1, 7, 0, 0); step(1, 5, 0, 0);
    chk("t2_err", int'(err), 1);
    chk("t2_err_cnt", int'(err_cnt), 1);
    chk("t2_unlock", int'(locked), 0);
    step(1, 2, 0, 0); step(1, 3, 0, 0); step(1, 0, 0, 0); step(1, 4, 0, 0);
    chk("t2_relock", int'(locked), 1);
    step(0, 0, 0, 1);
    chk("clrcnt_err", int'(err_cnt), 0);
    chk("clrcnt_lap", int'(lap_cnt), 0);

    // Mode 1: two full laps.
    step(0, 0, 1, 0);
    s1 = '{1, 4, 3, 5, 7, 6, 2, 1, 4, 3, 5, 7, 6, 2, 1};
    feed(1, 15, s1);
    chk("t3_lap", int'(lap_cnt), 2);
    chk("t3_err_cnt", int'(err_cnt), 0);
    step(1, 0, 1, 0);
    chk("t3_err0", int'(err), 1);
    chk("t3_hunt", int'(locked), 0);
    step(1, 1, 1, 0); step(1, 4, 1, 0); step(1, 3, 1, 0); step(1, 5, 1, 0);
    chk("t3_relock", int'(locked), 1);

    // Mode change while locked discards the sample.
    step(1, 7, 0, 0);
    chk("t4_err", int'(err), 0);
    chk("t4_locked", int'(locked), 0);
    chk("t4_err_cnt", int'(err_cnt), 1);

    // Saturation of err_cnt.
    for (int i = 0; i < 300; i++) begin
      step(1, 0, 0, 0); step(1, 4, 0, 0); step(1, 7, 0, 0); step(1, 2, 0, 0);
      step(1, 5, 0, 0);
    end
    chk("t5_sat", int'(err_cnt), 255);
    step(1, 0, 0, 0); step(1, 4, 0, 0); step(1, 7, 0, 0); step(1, 2, 0, 0);
    step(1, 5, 0, 1);
    chk("t5_clr_err", int'(err_cnt), 1);

    // Asynchronous clear between edges.
    step(1, 0, 0, 0); step(1, 4, 0, 0); step(1, 7, 0, 0); step(1, 2, 0, 0);
    step(1, 3, 0, 0); step(1, 0, 0, 0);
    chk("t6_pre", int'(locked), 1);
    #2 clr = 1;
    #1;
    chk("t6_locked", int'(locked), 0);
    chk("t6_err_cnt", int'(err_cnt), 0);
    chk("t6_lap", int'(lap_cnt), 0);
    model_reset();
    #1 clr = 0;
    step(1, 7, 0, 0);
    chk("t6_noerr", int'(err), 0);
    chk("t6_acq", int'(locked), 0);

    // Random phase, biased toward following the expected code.
    cm = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) cm = ~cm;
      if (m_st != ST_H && $urandom_range(0, 9) < 8) qq = m_exp;
      else qq = int'($urandom_range(0, 7));
      step($urandom_range(0, 9) != 0, qq, cm, $urandom_range(0, 49) == 0);
    end

    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
